// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32M definitions for the EX-stage mul/div unit.
//   - M-extension aluop encodings (0x10..0x17)
//   - is_m_op(): true when an aluop falls in the M range
//   - md_state_t: mul/div control FSM states
//   - DIV_ITERS: restoring-divider iterations (one quotient bit each)
package rv32_pkg;

  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_CALC,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } md_state_t;

  // M ops occupy 5'b10xxx
  function automatic logic is_m_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: iterative unsigned restoring divider.
//   clk, rst       clock, async active-high reset
//   load           capture dividend/divisor, clear remainder and counter
//   run            perform one iteration this cycle
//   dividend/divisor  unsigned operands (magnitudes)
//   iter_done      high on the cycle of the last iteration
//   quo, rem       quotient / remainder, final after iter_done edge
module muldiv_div_core
  import rv32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             iter_done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // quo doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits shift in at the bottom.
  assign trial = {rem, quo[WIDTH-1]};
  assign fits  = trial >= {1'b0, dvsr};
  // when fits, trial - dvsr < dvsr, so the low WIDTH bits are exact
  assign diff  = trial[WIDTH-1:0] - dvsr;

  assign iter_done = run && (cnt == CW'(DIV_ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
    end else if (load) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
      cnt  <= '0;
    end else if (run) begin
      quo  <= {quo[WIDTH-2:0], fits};
      rem  <= fits ? diff : trial[WIDTH-1:0];
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M execute unit (EX stage).
//   clk, rst   clock, async active-high reset
//   start      EX holds an M op; aluop/op_a/op_b from ID/EX (forwarded)
//   flush      kill in-flight op (redirect)
//   busy       stall into the pipeline busywait (combinational)
//   done       result valid this cycle (one pulse, DONE state)
//   result     held from DONE until the next op overwrites it
// MUL*: 2 busy cycles, done at T2. DIV/REM: 34 busy cycles, done at T34.
// With EARLY_OUT, divide-by-zero and signed overflow finish at T1.
module ex_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_t        state;
  logic [4:0]       op_q;
  logic [WIDTH:0]   a_ext, b_ext;
  logic             q_neg, r_neg;

  // ---- start-cycle decode ----
  logic             accept, is_div, is_rem, sgn_a, sgn_b, neg_a, neg_b;
  logic             div0, ovf, early, load;
  logic [WIDTH-1:0] abs_a, abs_b, early_res;

  assign accept = (state == ST_IDLE) && start && !flush && is_m_op(aluop);
  assign is_div = aluop[2];
  assign is_rem = aluop[1];
  assign sgn_a  = aluop inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sgn_b  = aluop inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign neg_a  = sgn_a && op_a[WIDTH-1];
  assign neg_b  = sgn_b && op_b[WIDTH-1];
  assign abs_a  = neg_a ? -op_a : op_a;
  assign abs_b  = neg_b ? -op_b : op_b;
  assign div0   = (op_b == '0);
  assign ovf    = sgn_b && (op_a == MIN_NEG) && (op_b == '1);
  assign early  = EARLY_OUT && (div0 || ovf);
  assign early_res = is_rem ? (div0 ? op_a : '0) : (div0 ? '1 : MIN_NEG);
  assign load   = accept && is_div && !early;

  assign busy = accept || (state inside {ST_MUL_CALC, ST_DIV_ITER, ST_DIV_FIX});

  // ---- multiplier ----
  // 33x33 signed product; the low 64 bits hold every bit any MUL* returns.
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mul_res;
  assign product = (2*WIDTH)'($signed(a_ext) * $signed(b_ext));
  assign mul_res = (op_q == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];

  // ---- divider ----
  logic             iter_done;
  logic [WIDTH-1:0] quo, rem, div_res;

  muldiv_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .run       (state == ST_DIV_ITER),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .iter_done (iter_done),
    .quo       (quo),
    .rem       (rem)
  );

  assign div_res = op_q[1] ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);

  // ---- control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_ext  <= '0;
      b_ext  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          op_q <= aluop;
          if (is_div) begin
            // x/0 keeps an all-ones quotient regardless of dividend sign
            q_neg <= (neg_a ^ neg_b) && !div0;
            r_neg <= neg_a;
            if (early) begin
              result <= early_res;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_DIV_ITER;
            end
          end else begin
            a_ext <= {neg_a, op_a};
            b_ext <= {neg_b, op_b};
            state <= ST_MUL_CALC;
          end
        end
        ST_MUL_CALC: if (flush) state <= ST_IDLE;
          else begin
            result <= mul_res;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        ST_DIV_ITER: if (flush) state <= ST_IDLE;
          else if (iter_done) state <= ST_DIV_FIX;
        ST_DIV_FIX: if (flush) state <= ST_IDLE;
          else begin
            result <= div_res;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        // start is ignored here: ID/EX still holds the finished op
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (EARLY_OUT=1).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_ex_muldiv_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  aluop = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_pass = 0;
  int n_total = 0;

  ex_muldiv_unit #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .op_a(op_a),
    .op_b(op_b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Issue one op with start high for T0 only; observe ncyc cycles from T0.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ncyc, output logic [31:0] res, output int done_cyc,
                        output int busy_cnt, output int done_cnt);
    res = 'x; done_cyc = -1; busy_cnt = 0; done_cnt = 0;
    @(negedge clk); start = 1'b1; aluop = op; op_a = a; op_b = b; #1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin @(negedge clk); start = 1'b0; #1; end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; res = result; end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0)
      $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int dc, bc, nd;
    logic [4:0]  ops [4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] av  [4] = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bv  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] ev  [4] = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], 5, r, dc, bc, nd);
      n_total++;
      if (r !== ev[i] || dc !== 2 || bc !== 2 || nd !== 1)
        $display("FAIL mul[%0d] op=%h: res=%h done_cyc=%0d busy_cycles=%0d dones=%0d, want %h 2 2 1",
                 i, ops[i], r, dc, bc, nd, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [31:0] r; int dc, bc, nd;
    logic [4:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] av  [4] = '{32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C};
    logic [31:0] ev  [4] = '{32'd14, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFE};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], 32'd7, 38, r, dc, bc, nd);
      n_total++;
      if (r !== ev[i] || dc !== 34 || bc !== 34 || nd !== 1)
        $display("FAIL div[%0d] op=%h: res=%h done_cyc=%0d busy_cycles=%0d dones=%0d, want %h 34 34 1",
                 i, ops[i], r, dc, bc, nd, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_early_out();
    logic [31:0] r; int dc, bc, nd;
    logic [4:0]  ops [5] = '{OP_DIV, OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] av  [5] = '{32'd5, 32'hFFFFFFF9, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] bv  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], 4, r, dc, bc, nd);
      n_total++;
      if (r !== ev[i] || dc !== 1 || bc !== 1 || nd !== 1)
        $display("FAIL early[%0d] op=%h: res=%h done_cyc=%0d busy_cycles=%0d dones=%0d, want %h 1 1 1",
                 i, ops[i], r, dc, bc, nd, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] r; int dc, bc, nd;
    @(negedge clk); start = 1'b1; aluop = OP_DIVU; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1; #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0)
      $display("FAIL reset_mid_div: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    run_op(OP_MUL, 32'd3, 32'd4, 5, r, dc, bc, nd);
    n_total++;
    if (r !== 32'd12 || dc !== 2 || bc !== 2 || nd !== 1)
      $display("FAIL mul_after_reset: res=%h done_cyc=%0d busy_cycles=%0d dones=%0d, want 0000000c 2 2 1",
               r, dc, bc, nd);
    else n_pass++;
  endtask

  task automatic test_flush();
    int nd = 0;
    // result holds 12 from the previous test
    @(negedge clk); start = 1'b1; aluop = OP_DIV; op_a = 32'd100; op_b = 32'd7;
    repeat (5) begin @(negedge clk); start = 1'b0; end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL flush_idle: busy=%b, want 0", busy);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) nd++;
      @(negedge clk); #1;
    end
    n_total++;
    if (nd !== 0 || result !== 32'd12)
      $display("FAIL flush_no_done: dones=%0d result=%h, want 0 0000000c", nd, result);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); start = 1'b1; aluop = OP_MUL; op_a = 32'd3; op_b = 32'd5;
    repeat (2) @(negedge clk);
    #1;  // T2: DONE with start still high
    n_total++;
    if (done !== 1'b1 || result !== 32'd15 || busy !== 1'b0)
      $display("FAIL b2b_done: done=%b result=%h busy=%b, want 1 0000000f 0", done, result, busy);
    else n_pass++;
    @(negedge clk); op_a = 32'd6; op_b = 32'd7; #1;  // T3: new op accepted
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b, want 1", busy);
    else n_pass++;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (done !== 1'b1 || result !== 32'd42)
      $display("FAIL b2b_second: done=%b result=%h, want 1 0000002a", done, result);
    else n_pass++;
  endtask

  task automatic test_no_start();
    // start+flush together, then a non-M opcode: neither may launch an op
    @(negedge clk); start = 1'b1; flush = 1'b1; aluop = OP_DIV; op_a = 32'd9; op_b = 32'd3; #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL start_flush: busy=%b, want 0", busy);
    else n_pass++;
    @(negedge clk); flush = 1'b0; aluop = 5'h03; #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL non_m_op: busy=%b done=%b, want 0 0", busy, done);
    else n_pass++;
    @(negedge clk); start = 1'b0; #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL stay_idle: busy=%b done=%b, want 0 0", busy, done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_early_out();
    test_reset_mid_div();
    test_flush();
    test_back_to_back();
    test_no_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
